// File: rtl/ipf_feeder.sv
// ipf_feeder: replays image/weight SRAM words into IPF on the load/compute/step schedule; valids and ctrl trail the reads by 1 cycle.
// No backpressure (IPF always accepts); finish aborts or ends a sequence. Define IPF_FEEDER_LOOP_EN to repeat rounds until finish.
module ipf_feeder #(
    parameter int DATA_W   = 64,
    parameter int I_DEPTH  = 16,
    parameter int W_DEPTH  = 9,
    parameter int I_BURST  = 8,
    parameter int W_LONG   = 5,
    parameter int W_SHORT  = 4,
    parameter int WAIT_CYC = 32,
    parameter int ROUNDS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       i_rd,
    output logic [$clog2(I_DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]          i_rdata,
    output logic                       w_rd,
    output logic [$clog2(W_DEPTH)-1:0] w_addr,
    input  logic [DATA_W-1:0]          w_rdata,
    output logic                       i_valid,
    output logic [DATA_W-1:0]          i_data,
    output logic                       w_valid,
    output logic [DATA_W-1:0]          w_data,
    output logic [2:0]                 ctrl,
    input  logic                       finish
);
    localparam int I_AW  = $clog2(I_DEPTH);
    localparam int W_AW  = $clog2(W_DEPTH);
    localparam int CNT_W = $clog2((I_BURST > W_LONG ? I_BURST : W_LONG) + 1);
    localparam int WC_W  = $clog2(WAIT_CYC + 1);
    localparam int RND_W = $clog2(ROUNDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_W, WAIT, STEP, END} state_t;

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic [WC_W-1:0]  wait_cnt;
    logic [RND_W-1:0] round;
    logic [I_AW-1:0]  i_ptr;
    logic [W_AW-1:0]  w_ptr;
    logic [RND_W-1:0] round_nxt;
    logic [CNT_W-1:0] w_last;
    logic             run_abort;

    function automatic logic [I_AW-1:0] i_step(input logic [I_AW-1:0] p);
        return (p == I_AW'(I_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [W_AW-1:0] w_step(input logic [W_AW-1:0] p);
        return (p == W_AW'(W_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign round_nxt = round + RND_W'(1);
    assign w_last    = round[0] ? CNT_W'(W_SHORT - 1) : CNT_W'(W_LONG - 1);
    assign run_abort = finish && (state != IDLE) && (state != END);
    assign busy      = (state != IDLE);

    // Memory data already lags its read by one cycle, so gating with the
    // delayed read enable drops in-flight words on abort or reset.
    assign i_data = i_valid ? i_rdata : '0;
    assign w_data = w_valid ? w_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            wait_cnt  <= '0;
            round     <= '0;
            i_ptr     <= '0;
            w_ptr     <= '0;
            done      <= 1'b0;
            i_rd      <= 1'b0;
            i_addr    <= '0;
            w_rd      <= 1'b0;
            w_addr    <= '0;
            i_valid   <= 1'b0;
            w_valid   <= 1'b0;
            ctrl      <= 3'd0;
        end else begin
            done    <= 1'b0;
            i_valid <= i_rd;
            w_valid <= w_rd;
            if (run_abort) begin
                state     <= IDLE;
                i_rd      <= 1'b0;
                w_rd      <= 1'b0;
                i_valid   <= 1'b0;
                w_valid   <= 1'b0;
                ctrl      <= 3'd0;
                round     <= '0;
                burst_cnt <= '0;
                wait_cnt  <= '0;
`ifdef IPF_FEEDER_LOOP_EN
                done      <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            burst_cnt <= '0;
                            if (!round[0]) begin
                                state  <= LOAD_I;
                                i_rd   <= 1'b1;
                                i_addr <= i_ptr;
                                i_ptr  <= i_step(i_ptr);
                            end else begin
                                state  <= LOAD_W;
                                w_rd   <= 1'b1;
                                w_addr <= w_ptr;
                                w_ptr  <= w_step(w_ptr);
                            end
                        end
                    end
                    LOAD_I: begin
                        if (burst_cnt == CNT_W'(I_BURST - 1)) begin
                            // Weight reads follow back-to-back so the valids never overlap.
                            burst_cnt <= '0;
                            i_rd      <= 1'b0;
                            state     <= LOAD_W;
                            w_rd      <= 1'b1;
                            w_addr    <= w_ptr;
                            w_ptr     <= w_step(w_ptr);
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                            i_addr    <= i_ptr;
                            i_ptr     <= i_step(i_ptr);
                        end
                    end
                    LOAD_W: begin
                        if (burst_cnt == w_last) begin
                            burst_cnt <= '0;
                            w_rd      <= 1'b0;
                            wait_cnt  <= '0;
                            state     <= WAIT;
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                            w_addr    <= w_ptr;
                            w_ptr     <= w_step(w_ptr);
                        end
                    end
                    WAIT: begin
                        ctrl <= 3'd1;
                        if (wait_cnt == WC_W'(WAIT_CYC - 1)) begin
                            wait_cnt <= '0;
                            state    <= STEP;
                        end else begin
                            wait_cnt <= wait_cnt + WC_W'(1);
                        end
                    end
                    STEP: begin
                        ctrl      <= 3'd2;
                        round     <= round_nxt;
                        burst_cnt <= '0;
                        if (round_nxt < RND_W'(ROUNDS)) begin
                            if (!round_nxt[0]) begin
                                state  <= LOAD_I;
                                i_rd   <= 1'b1;
                                i_addr <= i_ptr;
                                i_ptr  <= i_step(i_ptr);
                            end else begin
                                state  <= LOAD_W;
                                w_rd   <= 1'b1;
                                w_addr <= w_ptr;
                                w_ptr  <= w_step(w_ptr);
                            end
                        end else begin
`ifdef IPF_FEEDER_LOOP_EN
                            round  <= '0;
                            state  <= LOAD_I;
                            i_rd   <= 1'b1;
                            i_addr <= i_ptr;
                            i_ptr  <= i_step(i_ptr);
`else
                            state  <= END;
`endif
                        end
                    end
                    END: begin
                        ctrl <= 3'd0;
                        if (finish) begin
                            done  <= 1'b1;
                            round <= '0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ipf_feeder.sv
// Bench for ipf_feeder: directed vector table, abort/reset sequences, then random sequences against a schedule model.
`timescale 1ns/1ps
module tb_ipf_feeder;
    localparam int DATA_W  = 64;
    localparam int I_DEPTH = 16;
    localparam int W_DEPTH = 9;
    localparam int MAXC    = 200;

    typedef logic [134:0] obs_t;
    typedef struct {
        int          cyc;
        logic        busy;
        logic        iv;
        logic [63:0] id;
        logic        wv;
        logic [63:0] wd;
        logic [2:0]  ctrl;
    } vec_t;

    localparam obs_t ZERO = '0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              busy, done, i_rd, w_rd, i_valid, w_valid;
    logic [3:0]        i_addr, w_addr;
    logic [DATA_W-1:0] i_rdata = '0;
    logic [DATA_W-1:0] w_rdata = '0;
    logic [DATA_W-1:0] i_data, w_data;
    logic [2:0]        ctrl;

    logic [63:0] imem [I_DEPTH];
    logic [63:0] wmem [W_DEPTH];

    logic        e_iv   [MAXC+1];
    logic [63:0] e_id   [MAXC+1];
    logic        e_wv   [MAXC+1];
    logic [63:0] e_wd   [MAXC+1];
    logic [2:0]  e_ctrl [MAXC+1];

    int compared = 0;
    int mismatched = 0;
    int ip = 0;
    int wp = 0;

    ipf_feeder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
        .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid), .w_data(w_data),
        .ctrl(ctrl), .finish(finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (i_rd) i_rdata <= imem[i_addr];
        if (w_rd) w_rdata <= wmem[w_addr];
    end

    function automatic obs_t pk(input logic b, input logic d, input logic iv, input logic [63:0] id,
                                input logic wv, input logic [63:0] wd, input logic [2:0] c);
        return {b, d, iv, id, wv, wd, c};
    endfunction

    function automatic obs_t cur();
        return pk(busy, done, i_valid, i_data, w_valid, w_data, ctrl);
    endfunction

    function automatic vec_t mk(input int cyc, input int b, input int iv, input int id,
                                input int wv, input int wd, input int c);
        vec_t v;
        v.cyc = cyc; v.busy = (b != 0); v.iv = (iv != 0); v.id = 64'(id);
        v.wv = (wv != 0); v.wd = 64'(wd); v.ctrl = 3'(c);
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc %0d: got busy=%0b done=%0b iv=%0b id=%0h wv=%0b wd=%0h ctrl=%0d | want busy=%0b done=%0b iv=%0b id=%0h wv=%0b wd=%0h ctrl=%0d",
                     name, cyc, act[134], act[133], act[132], act[131:68], act[67], act[66:3], act[2:0],
                     exp[134], exp[133], exp[132], exp[131:68], exp[67], exp[66:3], exp[2:0]);
        end
    endtask

    // Schedule per round: even rounds load 8 image + 5 weight words, odd rounds 4 weight
    // words; then 32 compute cycles and one step. Outputs appear one cycle after each slot.
    task automatic build_model(input int ip0, input int wp0);
        int t, pi, pw, nw;
        int cv [MAXC+1];
        logic [2:0] held;
        pi = ip0; pw = wp0; t = 0;
        for (int k = 0; k <= MAXC; k++) begin
            e_iv[k] = 1'b0; e_id[k] = '0; e_wv[k] = 1'b0; e_wd[k] = '0; cv[k] = -1;
        end
        cv[0] = 0;
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) begin
                for (int k = 0; k < 8; k++) begin
                    e_iv[t+1] = 1'b1; e_id[t+1] = imem[pi % I_DEPTH]; pi++; t++;
                end
            end
            nw = (r % 2 == 0) ? 5 : 4;
            for (int k = 0; k < nw; k++) begin
                e_wv[t+1] = 1'b1; e_wd[t+1] = wmem[pw % W_DEPTH]; pw++; t++;
            end
            for (int k = 1; k <= 32; k++) cv[t+k] = 1;
            t += 32;
            cv[t+1] = 2;
            t++;
        end
        cv[t+1] = 0;
        held = 3'd0;
        for (int k = 0; k <= MAXC; k++) begin
            if (cv[k] >= 0) held = 3'(cv[k]);
            e_ctrl[k] = held;
        end
    endtask

    task automatic run_seq(input int abort_at, input int end_wait);
        int last, n_i, n_w;
        bit ab;
        ab = (abort_at >= 0);
        last = ab ? abort_at : 167 + end_wait;
        build_model(ip, wp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= last; c++) begin
            check("rand_seq", c, cur(), pk(1'b1, 1'b0, e_iv[c], e_id[c], e_wv[c], e_wd[c], e_ctrl[c]));
            start = ($urandom_range(0, 7) == 0);
            finish = (c == last);
            @(negedge clk);
        end
        start = 1'b0;
        finish = 1'b0;
        check(ab ? "rand_abort" : "rand_done", last + 1, cur(),
              ab ? ZERO : pk(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 3'd0));
        @(negedge clk);
        check("rand_idle", last + 2, cur(), ZERO);
        n_i = 0; n_w = 0;
        for (int k = 1; k <= last + 1 && k <= MAXC; k++) begin
            n_i += int'(e_iv[k]);
            n_w += int'(e_wv[k]);
        end
        ip = (ip + n_i) % I_DEPTH;
        wp = (wp + n_w) % W_DEPTH;
    endtask

    initial begin
        vec_t vec[$];
        int c;
        vec.push_back(mk(0,   1, 0, 0,  0, 0, 0));
        vec.push_back(mk(1,   1, 1, 0,  0, 0, 0));
        vec.push_back(mk(5,   1, 1, 4,  0, 0, 0));
        vec.push_back(mk(8,   1, 1, 7,  0, 0, 0));
        vec.push_back(mk(9,   1, 0, 0,  1, 0, 0));
        vec.push_back(mk(13,  1, 0, 0,  1, 4, 0));
        vec.push_back(mk(14,  1, 0, 0,  0, 0, 1));
        vec.push_back(mk(45,  1, 0, 0,  0, 0, 1));
        vec.push_back(mk(46,  1, 0, 0,  0, 0, 2));
        vec.push_back(mk(47,  1, 0, 0,  1, 5, 2));
        vec.push_back(mk(50,  1, 0, 0,  1, 8, 2));
        vec.push_back(mk(51,  1, 0, 0,  0, 0, 1));
        vec.push_back(mk(83,  1, 0, 0,  0, 0, 2));
        vec.push_back(mk(84,  1, 1, 8,  0, 0, 2));
        vec.push_back(mk(91,  1, 1, 15, 0, 0, 2));
        vec.push_back(mk(92,  1, 0, 0,  1, 0, 2));
        vec.push_back(mk(96,  1, 0, 0,  1, 4, 2));
        vec.push_back(mk(97,  1, 0, 0,  0, 0, 1));
        vec.push_back(mk(129, 1, 0, 0,  0, 0, 2));
        vec.push_back(mk(130, 1, 0, 0,  1, 5, 2));
        vec.push_back(mk(133, 1, 0, 0,  1, 8, 2));
        vec.push_back(mk(134, 1, 0, 0,  0, 0, 1));
        vec.push_back(mk(165, 1, 0, 0,  0, 0, 1));
        vec.push_back(mk(166, 1, 0, 0,  0, 0, 2));
        vec.push_back(mk(167, 1, 0, 0,  0, 0, 0));
        vec.push_back(mk(170, 1, 0, 0,  0, 0, 0));

        for (int k = 0; k < I_DEPTH; k++) imem[k] = 64'(k);
        for (int k = 0; k < W_DEPTH; k++) wmem[k] = 64'(k);

        @(negedge clk);
        check("reset_out", 0, cur(), ZERO);
        check("reset_rd", 0, obs_t'({i_rd, w_rd, i_addr, w_addr}), ZERO);
        rst = 1'b0;
        @(negedge clk);

`ifdef IPF_FEEDER_LOOP_EN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 300; k++) begin
            if (k == 167) check("loop_wrap", k, cur(), pk(1'b1, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 3'd2));
            if (k == 174) check("loop_word7", k, cur(), pk(1'b1, 1'b0, 1'b1, 64'd7, 1'b0, 64'd0, 3'd2));
            if (k >= 14) check("loop_ctrl", k, obs_t'(ctrl != 3'd0), obs_t'(1'b1));
            finish = (k == 300);
            @(negedge clk);
        end
        finish = 1'b0;
        check("loop_done", 301, cur(), pk(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 3'd0));
        @(negedge clk);
        check("loop_done_once", 302, cur(), ZERO);
`else
        // Full nominal sequence against the hand-derived vector table.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        foreach (vec[n]) begin
            while (c < vec[n].cyc) begin
                @(negedge clk);
                c++;
            end
            check("vec", c, cur(), pk(vec[n].busy, 1'b0, vec[n].iv, vec[n].id, vec[n].wv, vec[n].wd, vec[n].ctrl));
        end
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check("done_pulse", c + 1, cur(), pk(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 3'd0));
        @(negedge clk);
        check("done_once", c + 2, cur(), ZERO);

        // Abort in the third cycle of the first weight load; pointers continue from 0/0.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_pre", 10, cur(), pk(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'd1, 3'd0));
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check("abort", 11, cur(), ZERO);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 12 + k, cur(), ZERO);
        end

        // Async reset mid image load; image pointer persisted at 8 before it.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre", 3, cur(), pk(1'b1, 1'b0, 1'b1, 64'd10, 1'b0, 64'd0, 3'd0));
        #2 rst = 1'b1;
        #1;
        check("rst_async", 3, cur(), ZERO);
        check("rst_async_rd", 3, obs_t'({i_rd, w_rd, i_addr, w_addr}), ZERO);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_restart0", 1, cur(), pk(1'b1, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 3'd0));
        @(negedge clk);
        check("rst_restart1", 2, cur(), pk(1'b1, 1'b0, 1'b1, 64'd1, 1'b0, 64'd0, 3'd0));

        // Random memories, idle gaps, start noise while busy, random aborts.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ip = 0;
        wp = 0;
        for (int k = 0; k < I_DEPTH; k++) imem[k] = {$urandom, $urandom};
        for (int k = 0; k < W_DEPTH; k++) wmem[k] = {$urandom, $urandom};
        for (int s = 0; s < 6; s++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_seq(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 165)) : -1,
                    int'($urandom_range(0, 3)));
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
